// File: rtl/stack_processor_top.sv
// Minimal stack processor: 256x16 program ROM, 32-bit LIFO data stack, prescaler-paced execution.
// Optional feature macro: STACK_MUL_EN (opcode A = MUL); undefined makes opcode A illegal.
`timescale 1ns/1ps
module stack_processor_top #(
    parameter int    INSTRUCTION_CLOCK_BIT = 22,
    parameter int    STACK_DEPTH           = 16,
    parameter string PROGRAM_FILE          = ""
) (
    input  logic        CLK,
    input  logic        RST_N,
    output logic        LED,
    output logic [31:0] STACK_TOP_ITEM,
    output logic [31:0] STACK_ITEM_COUNT
);
    localparam int            IW   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int            CW   = IW + 1;
    localparam logic [CW-1:0] FULL = CW'(STACK_DEPTH);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_HALT  = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    logic [15:0]   r_rom [256];
    logic [31:0]   r_stack [STACK_DEPTH];
    logic [31:0]   r_presc;
    logic [7:0]    r_pc;
    logic [CW-1:0] r_count;
    logic [31:0]   r_top;
    logic          r_led;
    logic [1:0]    r_state;

    initial begin
        for (int i = 0; i < 256; i++) r_rom[i] = 16'h0000;
        if (PROGRAM_FILE == "") begin
            r_rom[0] = 16'h1003;
            r_rom[1] = 16'h1004;
            r_rom[2] = 16'h3000;
            r_rom[3] = 16'h1001;
            r_rom[4] = 16'h9000;
            r_rom[5] = 16'hF000;
        end
    end

    logic          w_strobe, w_exec;
    logic [15:0]   w_instr;
    logic [3:0]    w_op;
    logic [31:0]   w_imm;
    logic [CW-1:0] w_cm1, w_cm2;
    logic [IW-1:0] w_i_push, w_i_top, w_i_a;
    logic [31:0]   w_a, w_below, w_alu;

    assign w_strobe = &r_presc[INSTRUCTION_CLOCK_BIT:0];
    assign w_exec   = w_strobe && (r_state == ST_RUN);
    assign w_instr  = r_rom[r_pc];
    assign w_op     = w_instr[15:12];
    assign w_imm    = {20'd0, w_instr[11:0]};
    assign w_cm1    = r_count - CW'(1);
    assign w_cm2    = r_count - CW'(2);
    assign w_i_push = r_count[IW-1:0];
    assign w_i_top  = w_cm1[IW-1:0];
    assign w_i_a    = w_cm2[IW-1:0];
    assign w_a      = r_stack[w_i_a];
    // r_top mirrors the top RAM entry, so after a pop the new top is the old second entry.
    assign w_below  = (r_count >= CW'(2)) ? w_a : 32'd0;

    always_comb begin
        w_alu = w_a + r_top;
        case (w_op)
            4'h4:    w_alu = w_a - r_top;
`ifdef STACK_MUL_EN
            4'hA:    w_alu = w_a * r_top;
`endif
            default: w_alu = w_a + r_top;
        endcase
    end

    logic          w_fault, w_halt, w_illegal, w_grow;
    logic [CW-1:0] w_need, w_cnt_nxt;
    logic [7:0]    w_pc_nxt;
    logic [31:0]   w_top_nxt;
    logic          w_led_nxt;
    logic          w_we0, w_we1;
    logic [IW-1:0] w_wa0, w_wa1;
    logic [31:0]   w_wd0, w_wd1;

    always_comb begin
        w_pc_nxt  = r_pc + 8'd1;
        w_cnt_nxt = r_count;
        w_top_nxt = r_top;
        w_led_nxt = r_led;
        w_need    = '0;
        w_grow    = 1'b0;
        w_illegal = 1'b0;
        w_halt    = 1'b0;
        w_we0     = 1'b0;
        w_wa0     = w_i_push;
        w_wd0     = 32'd0;
        w_we1     = 1'b0;
        w_wa1     = w_i_a;
        w_wd1     = 32'd0;
        case (w_op)
            4'h0: ;
            4'h1: begin
                w_grow    = 1'b1;
                w_we0     = 1'b1;
                w_wd0     = w_imm;
                w_cnt_nxt = r_count + CW'(1);
                w_top_nxt = w_imm;
            end
            4'h2: begin
                w_need    = CW'(1);
                w_cnt_nxt = w_cm1;
                w_top_nxt = w_below;
            end
`ifdef STACK_MUL_EN
            4'h3, 4'h4, 4'hA: begin
`else
            4'h3, 4'h4: begin
`endif
                w_need    = CW'(2);
                w_we0     = 1'b1;
                w_wa0     = w_i_a;
                w_wd0     = w_alu;
                w_cnt_nxt = w_cm1;
                w_top_nxt = w_alu;
            end
            4'h5: begin
                w_need    = CW'(1);
                w_grow    = 1'b1;
                w_we0     = 1'b1;
                w_wd0     = r_top;
                w_cnt_nxt = r_count + CW'(1);
            end
            4'h6: begin
                w_need    = CW'(2);
                w_we0     = 1'b1;
                w_wa0     = w_i_top;
                w_wd0     = w_a;
                w_we1     = 1'b1;
                w_wd1     = r_top;
                w_top_nxt = w_a;
            end
            4'h7: w_pc_nxt = w_imm[7:0];
            4'h8: begin
                w_need    = CW'(1);
                w_cnt_nxt = w_cm1;
                w_top_nxt = w_below;
                if (r_top == 32'd0) w_pc_nxt = w_imm[7:0];
            end
            4'h9: begin
                w_need    = CW'(1);
                w_cnt_nxt = w_cm1;
                w_top_nxt = w_below;
                w_led_nxt = r_top[0];
            end
            4'hF: begin
                w_halt   = 1'b1;
                w_pc_nxt = r_pc;
            end
            default: w_illegal = 1'b1;
        endcase
        w_fault = w_illegal || (r_count < w_need) || (w_grow && (r_count == FULL));
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_presc <= 32'd0;
            r_pc    <= 8'd0;
            r_count <= '0;
            r_top   <= 32'd0;
            r_led   <= 1'b0;
            r_state <= ST_RUN;
        end else begin
            r_presc <= r_presc + 32'd1;
            if (w_exec) begin
                if (w_fault) begin
                    r_state <= ST_FAULT;
                    r_led   <= 1'b1;
                end else begin
                    r_pc    <= w_pc_nxt;
                    r_count <= w_cnt_nxt;
                    r_top   <= w_top_nxt;
                    r_led   <= w_led_nxt;
                    if (w_halt) r_state <= ST_HALT;
                end
            end
        end
    end

    // Stack RAM carries no reset; only entries below r_count are ever observed.
    always_ff @(posedge CLK) begin
        if (w_exec && !w_fault) begin
            if (w_we0) r_stack[w_wa0] <= w_wd0;
            if (w_we1) r_stack[w_wa1] <= w_wd1;
        end
    end

    assign LED              = r_led;
    assign STACK_TOP_ITEM   = r_top;
    assign STACK_ITEM_COUNT = 32'(r_count);
endmodule

// File: tb/tb_stack_processor_top.sv
// Directed bench for stack_processor_top: built-in program, table of small programs, reset and overflow sequences.
`timescale 1ns/1ps
module tb_stack_processor_top;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        led, led4;
    logic [31:0] top, top4, cnt, cnt4;

    always #5 clk = ~clk;

    stack_processor_top #(.INSTRUCTION_CLOCK_BIT(2), .STACK_DEPTH(16)) dut (
        .CLK(clk), .RST_N(rst_n), .LED(led),
        .STACK_TOP_ITEM(top), .STACK_ITEM_COUNT(cnt)
    );

    stack_processor_top #(.INSTRUCTION_CLOCK_BIT(2), .STACK_DEPTH(4)) dut4 (
        .CLK(clk), .RST_N(rst_n), .LED(led4),
        .STACK_TOP_ITEM(top4), .STACK_ITEM_COUNT(cnt4)
    );

    typedef struct {
        string              name;
        logic [0:7][15:0]   prog;
        logic [31:0]        top;
        logic [31:0]        cnt;
        logic               led;
    } vec_t;

    vec_t vecs[12];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic load(input logic [0:7][15:0] p);
        for (int i = 0; i < 256; i++) dut.r_rom[i] = 16'h0000;
        for (int i = 0; i < 8; i++) dut.r_rom[i] = p[i];
    endtask

    // Reset, load, and release on a falling edge so the next rising edge is edge 1.
    task automatic restart(input logic [0:7][15:0] p);
        @(negedge clk);
        rst_n = 1'b0;
        load(p);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{"sub",       {16'h1005,16'h1003,16'h4000,16'hF000,64'h0},            32'h2,        32'd1, 1'b0};
        vecs[1]  = '{"sub_wrap",  {16'h1000,16'h1001,16'h4000,16'hF000,64'h0},            32'hFFFFFFFF, 32'd1, 1'b0};
        vecs[2]  = '{"underflow", {16'h1001,16'h3000,96'h0},                              32'h1,        32'd1, 1'b1};
        vecs[3]  = '{"jz_taken",  {16'h1000,16'h8003,16'h7000,16'h1009,16'hF000,48'h0},   32'h9,        32'd1, 1'b0};
        vecs[4]  = '{"jz_not",    {16'h1001,16'h8003,16'h1007,16'hF000,64'h0},            32'h7,        32'd1, 1'b0};
`ifdef STACK_MUL_EN
        vecs[5]  = '{"mul",       {16'h1006,16'h1007,16'hA000,16'hF000,64'h0},            32'h2A,       32'd1, 1'b0};
`else
        vecs[5]  = '{"mul_fault", {16'h1006,16'h1007,16'hA000,16'hF000,64'h0},            32'h7,        32'd2, 1'b1};
`endif
        vecs[6]  = '{"swap_sub",  {16'h1002,16'h1005,16'h6000,16'h4000,16'hF000,48'h0},   32'h3,        32'd1, 1'b0};
        vecs[7]  = '{"dup_add",   {16'h1009,16'h5000,16'h3000,16'hF000,64'h0},            32'h12,       32'd1, 1'b0};
        vecs[8]  = '{"pop_empty", {16'h1004,16'h2000,16'hF000,80'h0},                     32'h0,        32'd0, 1'b0};
        vecs[9]  = '{"illegal",   {16'h1001,16'hB000,16'hF000,80'h0},                     32'h1,        32'd1, 1'b1};
        vecs[10] = '{"led_off",   {16'h1001,16'h9000,16'h1000,16'h9000,16'hF000,48'h0},   32'h0,        32'd0, 1'b0};
        vecs[11] = '{"jmp",       {16'h7003,16'h1001,16'h0000,16'h1005,16'hF000,48'h0},   32'h5,        32'd1, 1'b0};

        #1;
        // Five pushes into a four-deep stack; the fifth overflows.
        for (int i = 0; i < 256; i++) dut4.r_rom[i] = 16'h0000;
        for (int i = 0; i < 5; i++) dut4.r_rom[i] = 16'h1001 + 16'(i);
        dut4.r_rom[5] = 16'hF000;

        #11;
        chk("reset_top", top, 32'd0);
        chk("reset_cnt", cnt, 32'd0);
        chk("reset_led", {31'd0, led}, 32'd0);

        // Built-in program, first strobe lands on edge 8.
        @(negedge clk);
        rst_n = 1'b1;
        repeat (7) @(posedge clk);
        #1 chk("builtin_edge7_cnt", cnt, 32'd0);
        @(posedge clk);
        #1 chk("builtin_edge8_cnt", cnt, 32'd1);
        chk("builtin_edge8_top", top, 32'd3);
        repeat (990) @(posedge clk);
        #1;
        chk("builtin_10us_top", top, 32'd7);
        chk("builtin_10us_cnt", cnt, 32'd1);
        chk("builtin_10us_led", {31'd0, led}, 32'd1);

        chk("overflow_cnt", cnt4, 32'd4);
        chk("overflow_led", {31'd0, led4}, 32'd1);
        chk("overflow_top", top4, 32'd4);

        for (int v = 0; v < 12; v++) begin
            restart(vecs[v].prog);
            repeat (8 * 12) @(posedge clk);
            #1;
            chk({vecs[v].name, "_top"}, top, vecs[v].top);
            chk({vecs[v].name, "_cnt"}, cnt, vecs[v].cnt);
            chk({vecs[v].name, "_led"}, {31'd0, led}, {31'd0, vecs[v].led});
            repeat (24) @(posedge clk);
            #1;
            chk({vecs[v].name, "_frozen_top"}, top, vecs[v].top);
            chk({vecs[v].name, "_frozen_cnt"}, cnt, vecs[v].cnt);
        end

        // Asynchronous reset in the middle of a run, then the first-strobe timing again.
        restart({16'h1003,16'h1004,16'h3000,16'h1001,16'h9000,16'hF000,32'h0});
        repeat (20) @(posedge clk);
        #1 chk("midrun_pre_cnt", cnt, 32'd2);
        chk("midrun_pre_top", top, 32'd4);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrun_rst_top", top, 32'd0);
        chk("midrun_rst_cnt", cnt, 32'd0);
        chk("midrun_rst_led", {31'd0, led}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (7) @(posedge clk);
        #1 chk("midrun_edge7_cnt", cnt, 32'd0);
        @(posedge clk);
        #1 chk("midrun_edge8_cnt", cnt, 32'd1);
        chk("midrun_edge8_top", top, 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
